counter_ctrl: RTL and testbench



---
 rtl/counter_ctrl.sv | 147 ++++++++++++++
 tb/tb_counter_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_ctrl.sv
// counter_ctrl: sequencing controller for the 8-bit loadable up-counter.
// Preloads the counter on a start command, then issues prescaled enable
// strobes until the counter reaches the programmed end value, reporting
// busy/done to the host. All outputs are registered.
module counter_ctrl #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            start_val,
  input  logic [7:0]            end_val,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  pause,
  input  logic                  abort,
  input  logic [7:0]            count,
  output logic                  load,
  output logic [7:0]            load_val,
  output logic                  enable,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]            state;
  logic [PRESCALE_W-1:0] psc_cnt;
  logic [7:0]            start_r;
  logic [7:0]            end_r;
  logic [PRESCALE_W-1:0] prescale_r;

  logic accept;
  logic tick;
  logic term;
  logic empty_run;

  // Decode of the per-cycle events shared by the register blocks below.
  always_comb begin
    accept    = 1'b0;
    tick      = 1'b0;
    term      = 1'b0;
    empty_run = 1'b0;
    accept    = (state == S_IDLE) && start && !abort;
    tick      = (psc_cnt == prescale_r);
    // The strobe in flight advances the counter on this edge; if it brings
    // the counter onto end_r we must stop here so it never goes past.
    term      = (state == S_RUN) && enable && (count == (end_r - 8'd1));
    empty_run = (start_r == end_r);
  end

  // Capture of the command operands; only a start accepted in IDLE updates them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_r    <= '0;
      end_r      <= '0;
      prescale_r <= '0;
    end else if (accept) begin
      start_r    <= start_val;
      end_r      <= end_val;
      prescale_r <= prescale;
    end
  end

  // Prescale counter: cleared on leaving LOAD, frozen by pause, wraps on tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_cnt <= '0;
    end else if (!abort) begin
      if (state == S_LOAD) begin
        psc_cnt <= '0;
      end else if (state == S_RUN && !pause) begin
        if (tick) begin
          psc_cnt <= '0;
        end else begin
          psc_cnt <= psc_cnt + 1'b1;
        end
      end
    end
  end

  // Main FSM and registered outputs; abort overrides every state but keeps load_val.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      load     <= 1'b0;
      load_val <= '0;
      enable   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (abort) begin
      state  <= S_IDLE;
      load   <= 1'b0;
      enable <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= S_LOAD;
            load     <= 1'b1;
            load_val <= start_val;
            busy     <= 1'b1;
          end
        end
        S_LOAD: begin
          load <= 1'b0;
          if (empty_run) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (term) begin
            state  <= S_DONE;
            enable <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else if (pause) begin
            enable <= 1'b0;
          end else begin
            enable <= tick;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          load   <= 1'b0;
          enable <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Testbench for counter_ctrl: models the downstream 8-bit loadable counter
// and checks each operation against expectations queued when it is launched.
module tb_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] start_val;
  logic [7:0] end_val;
  logic [7:0] prescale;
  logic       pause;
  logic       abort;
  logic [7:0] count;
  logic       load;
  logic [7:0] load_val;
  logic       enable;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  counter_ctrl #(.PRESCALE_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .start_val (start_val),
    .end_val   (end_val),
    .prescale  (prescale),
    .pause     (pause),
    .abort     (abort),
    .count     (count),
    .load      (load),
    .load_val  (load_val),
    .enable    (enable),
    .busy      (busy),
    .done      (done)
  );

  // Downstream loadable up-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count <= '0;
    else if (load)   count <= load_val;
    else if (enable) count <= count + 8'd1;
  end

  int    n_checks = 0;
  int    n_pass   = 0;
  string tag_q[$];
  int    exp_q[$];

  function automatic void expect_val(input string t, input int v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endfunction

  function automatic void check(input logic [31:0] obs);
    string t;
    int    e;
    n_checks++;
    if (exp_q.size() == 0) begin
      t = "no_expectation";
      e = -1;
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
    end
    assert (obs === 32'(e)) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", t, obs, e);
  endfunction

  // One complete operation; plen>0 holds pause for plen edges after the first enable,
  // poke_done raises start during the DONE cycle, which must be ignored.
  task automatic run_op(input logic [7:0] sv, input logic [7:0] ev,
                        input logic [7:0] ps, input int plen, input bit poke_done);
    int n;
    int exp_edge;
    int loads = 0, enables = 0, lv = -1, gap = 0, en_paused = 0;
    int done_edge = -1, cnt_done = -1, busy_done = -1;
    int pause_left = 0;
    bit seen_en = 1'b0;
    n = int'(8'(ev - sv));
    exp_edge = (n == 0) ? 1 : 3 + int'(ps) + (n - 1) * (int'(ps) + 1) + plen;
    expect_val("load_cycles", 1);
    expect_val("load_val", int'(sv));
    expect_val("enables", n);
    expect_val("busy_gap", 0);
    expect_val("enable_during_pause", 0);
    expect_val("done_edge", exp_edge);
    expect_val("count_at_done", int'(ev));
    expect_val("busy_at_done", 0);
    expect_val("done_after", 0);
    expect_val("count_after", int'(ev));
    expect_val("load_after_done", 0);

    start = 1'b1; start_val = sv; end_val = ev; prescale = ps;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        start = 1'b0; start_val = ~sv; end_val = ~ev; prescale = 8'hFF;
      end
      if (pause) begin
        en_paused += int'(enable);
        pause_left--;
        if (pause_left == 0) pause = 1'b0;
      end
      if (load) begin loads++; lv = int'(load_val); end
      if (enable) enables++;
      if ((load || enable) && !busy) gap++;
      if (enable && !seen_en) begin
        seen_en = 1'b1;
        if (plen > 0) begin pause = 1'b1; pause_left = plen; end
      end
      if (done) begin
        done_edge = i; cnt_done = int'(count); busy_done = int'(busy);
        break;
      end
    end
    pause = 1'b0;
    if (poke_done) begin start = 1'b1; start_val = 8'd99; end_val = 8'd120; end
    @(posedge clk); #1;
    start = 1'b0;
    check(32'(loads));
    check(32'(lv));
    check(32'(enables));
    check(32'(gap));
    check(32'(en_paused));
    check(32'(done_edge));
    check(32'(cnt_done));
    check(32'(busy_done));
    check(32'(done));
    check(32'(count));
    check(32'(load));
  endtask

  // Start a long run and stop right after the counter settles on 7 between strobes.
  task automatic run_to_seven(output bit found, output int extra_loads);
    found = 1'b0;
    extra_loads = 0;
    start = 1'b1; start_val = 8'd0; end_val = 8'd200; prescale = 8'd3;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (i > 0 && load) extra_loads++;
      // A start while running must be ignored.
      if (i == 4) begin start = 1'b1; start_val = 8'd50; end_val = 8'd60; end
      if (count == 8'd7 && !enable) begin found = 1'b1; break; end
    end
    start = 1'b0;
  endtask

  initial begin
    bit found;
    int extra;
    int any_done, any_load, any_en;
    rst_n = 1'b0; start = 1'b0; start_val = '0; end_val = '0;
    prescale = '0; pause = 1'b0; abort = 1'b0;

    // Reset state.
    expect_val("rst_load", 0);
    expect_val("rst_load_val", 0);
    expect_val("rst_enable", 0);
    expect_val("rst_busy", 0);
    expect_val("rst_done", 0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check(32'(load)); check(32'(load_val)); check(32'(enable));
    check(32'(busy)); check(32'(done));
    @(posedge clk); #1;

    run_op(8'd10,  8'd13, 8'd0, 0, 1'b1);
    run_op(8'd0,   8'd2,  8'd2, 0, 1'b0);
    run_op(8'd254, 8'd1,  8'd0, 0, 1'b0);
    run_op(8'd5,   8'd5,  8'd0, 0, 1'b0);
    run_op(8'd0,   8'd4,  8'd1, 5, 1'b0);

    // Abort at count==7, with a simultaneous start that must be dropped.
    expect_val("abort_reached7", 1);
    expect_val("abort_run_start_ignored", 0);
    expect_val("abort_enable", 0);
    expect_val("abort_busy", 0);
    expect_val("abort_done", 0);
    expect_val("abort_load", 0);
    expect_val("abort_hold_count", 7);
    expect_val("abort_no_done", 0);
    expect_val("abort_no_load", 0);
    expect_val("abort_no_enable", 0);
    run_to_seven(found, extra);
    check(32'(found));
    check(32'(extra));
    abort = 1'b1; start = 1'b1; start_val = 8'd9; end_val = 8'd20;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    check(32'(enable)); check(32'(busy)); check(32'(done)); check(32'(load));
    any_done = 0; any_load = 0; any_en = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      any_done += int'(done); any_load += int'(load); any_en += int'(enable);
    end
    check(32'(count)); check(32'(any_done)); check(32'(any_load)); check(32'(any_en));

    // Same run, interrupted by reset instead of abort.
    expect_val("rstmid_reached7", 1);
    expect_val("rstmid_run_start_ignored", 0);
    expect_val("rstmid_load", 0);
    expect_val("rstmid_load_val", 0);
    expect_val("rstmid_enable", 0);
    expect_val("rstmid_busy", 0);
    expect_val("rstmid_done", 0);
    expect_val("rstmid_count", 0);
    run_to_seven(found, extra);
    check(32'(found));
    check(32'(extra));
    #1 rst_n = 1'b0;
    #1;
    check(32'(load)); check(32'(load_val)); check(32'(enable));
    check(32'(busy)); check(32'(done)); check(32'(count));
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Fresh start after reset.
    run_op(8'd10, 8'd13, 8'd0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
